// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS-subset CPU family: next-PC source codes,
// default reset/exception vectors and the fetch/execute state encoding.
package cpu_pkg;

  localparam logic [2:0] PC_SRC_PLUS4  = 3'd0;
  localparam logic [2:0] PC_SRC_BRANCH = 3'd1;
  localparam logic [2:0] PC_SRC_JUMP   = 3'd2;
  localparam logic [2:0] PC_SRC_JR     = 3'd3;
  localparam logic [2:0] PC_SRC_ILLOP  = 3'd4;
  localparam logic [2:0] PC_SRC_XADR   = 3'd5;
  localparam logic [2:0] PC_SRC_XADR6  = 3'd6;
  localparam logic [2:0] PC_SRC_XADR7  = 3'd7;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] DEFAULT_XADR_VEC  = 32'h8000_0008;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: branch/jump target arithmetic, jr alignment
// trap, vector redirects, IRQ override and the matching EPC source.
module pc_next_mux
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] ILLOP_VEC = ADDR_W'(DEFAULT_ILLOP_VEC),
  parameter logic [ADDR_W-1:0] XADR_VEC  = ADDR_W'(DEFAULT_XADR_VEC)
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [25:0]       instr_field,
  input  logic [2:0]        pc_src,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              irq_eff,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] next_pc,
  output logic [ADDR_W-1:0] epc_next,
  output logic              epc_load,
  output logic              irq_take
);

  logic              sup;
  logic [ADDR_W-1:0] br_offset;
  logic [ADDR_W-1:0] conba;
  logic [ADDR_W-1:0] jump_target;

  assign sup       = pc[ADDR_W-1];
  assign pc_plus4  = pc + ADDR_W'(4);
  assign br_offset = {{(ADDR_W-18){instr_field[15]}}, instr_field[15:0], 2'b00};
  assign conba     = pc_plus4 + br_offset;

  // Jumps stay within the current privilege half of the address space.
  always_comb begin
    jump_target             = '0;
    jump_target[27:0]       = {instr_field[25:0], 2'b00};
    jump_target[ADDR_W-1]   = sup;
  end

  // An accepted user-mode IRQ outranks every pc_src, including ILLOP and a
  // misaligned jr, and resumes after the instruction being retired.
  always_comb begin
    next_pc  = pc_plus4;
    epc_next = pc_plus4;
    epc_load = 1'b0;
    irq_take = 1'b0;
    if (irq_eff && !sup) begin
      next_pc  = XADR_VEC;
      epc_load = 1'b1;
      irq_take = 1'b1;
    end else begin
      case (pc_src)
        PC_SRC_PLUS4: next_pc = pc_plus4;
        PC_SRC_BRANCH: begin
          if (br_taken) next_pc = {sup, conba[ADDR_W-2:0]};
        end
        PC_SRC_JUMP: next_pc = jump_target;
        PC_SRC_JR: begin
          if (jr_target[1:0] != 2'b00) begin
            next_pc  = ILLOP_VEC;
            epc_load = 1'b1;
          end else begin
            next_pc = jr_target;
          end
        end
        PC_SRC_ILLOP: begin
          next_pc  = ILLOP_VEC;
          epc_load = 1'b1;
        end
        default: begin
          next_pc  = XADR_VEC;
          epc_next = pc;
          epc_load = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Two-state fetch/execute PC sequencer with req/ack instruction fetch, EPC and
// supervisor-masked IRQ. Define IRQ_LATCH_EN to latch irq rising edges as pending.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEFAULT_RESET_PC),
  parameter logic [ADDR_W-1:0] ILLOP_VEC = ADDR_W'(DEFAULT_ILLOP_VEC),
  parameter logic [ADDR_W-1:0] XADR_VEC  = ADDR_W'(DEFAULT_XADR_VEC)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  input  logic              advance,
  input  logic [2:0]        pc_src,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              irq,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] epc,
  output logic              irq_take,
  output logic              supervisor
);

  seq_state_t        state;
  logic              retire;
  logic              irq_eff;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] epc_next;
  logic              epc_load;
  logic              take;

  assign retire     = (state == EXEC) && advance;
  assign imem_addr  = pc;
  assign supervisor = pc[ADDR_W-1];

  pc_next_mux #(
    .ADDR_W    (ADDR_W),
    .ILLOP_VEC (ILLOP_VEC),
    .XADR_VEC  (XADR_VEC)
  ) u_next_mux (
    .pc          (pc),
    .instr_field (instr[25:0]),
    .pc_src      (pc_src),
    .br_taken    (br_taken),
    .jr_target   (jr_target),
    .irq_eff     (irq_eff),
    .pc_plus4    (pc_plus4),
    .next_pc     (next_pc),
    .epc_next    (epc_next),
    .epc_load    (epc_load),
    .irq_take    (take)
  );

`ifdef IRQ_LATCH_EN
  logic irq_prev;
  logic pending;

  // A rising edge landing on the same clock as the take survives the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_prev <= 1'b0;
      pending  <= 1'b0;
    end else begin
      irq_prev <= irq;
      pending  <= (pending && !(retire && take)) || (irq && !irq_prev);
    end
  end

  assign irq_eff = pending;
`else
  assign irq_eff = irq;
`endif

  // Fetch holds the request until ack; execute holds the instruction until retired.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b1;
      epc         <= '0;
      irq_take    <= 1'b0;
    end else begin
      irq_take <= 1'b0;
      case (state)
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (advance) begin
            pc          <= next_pc;
            if (epc_load) epc <= epc_next;
            irq_take    <= take;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end
        end
      endcase
    end
  end

endmodule
